// File: rtl/vend_if.sv
// Coin, handshake and status signals between the vending scheduler and its
// coin mechanism, dispenser and change hopper.
interface vend_if;
  logic       I;
  logic       J;
  logic       cancel;
  logic       vend_ack;
  logic       chg_ack;
  logic       vend_req;
  logic       chg_req;
  logic       coin_reject;
  logic [3:0] credit;
  logic       busy;

  modport master (
    output I, J, cancel, vend_ack, chg_ack,
    input  vend_req, chg_req, coin_reject, credit, busy
  );

  modport slave (
    input  I, J, cancel, vend_ack, chg_ack,
    output vend_req, chg_req, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_scheduler.sv
// Coin-credit vending scheduler: accumulates Rs.5/Rs.10 coins, vends, pays change/refunds.
// Optional inactivity auto-refund in CREDIT is enabled by defining VEND_TIMEOUT_EN.
module vend_scheduler #(
  parameter int PRICE_UNITS = 3,
  parameter int MAX_UNITS   = 7,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic   clk,
  input logic   reset,
  vend_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_REFUND = 3'd4
  } state_t;

  localparam logic [4:0] MAX_L    = 5'(MAX_UNITS);
  localparam logic [4:0] PRICE5_L = 5'(PRICE_UNITS);
  localparam logic [3:0] PRICE4_L = 4'(PRICE_UNITS);

  state_t     state_r, state_s;
  logic [3:0] credit_r, credit_s;
  logic       vend_req_r, vend_req_s;
  logic       chg_req_r, chg_req_s;
  logic       coin_reject_r, coin_reject_s;
  logic       busy_r, busy_s;
  logic [4:0] sum_s;
  logic       accept_s;
  logic       hit_price_s;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_L = TMO_W'(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_r, tmo_s;
`endif

  // Next-state, next-credit and next-output decode
  always_comb begin
    state_s       = state_r;
    credit_s      = credit_r;
    vend_req_s    = 1'b0;
    chg_req_s     = 1'b0;
    coin_reject_s = 1'b0;
    sum_s         = {1'b0, credit_r} + (bus.J ? 5'd2 : 5'd1);
    accept_s      = bus.I && (sum_s <= MAX_L);
    hit_price_s   = (sum_s >= PRICE5_L);
`ifdef VEND_TIMEOUT_EN
    tmo_s         = '0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          credit_s   = sum_s[3:0];
          vend_req_s = hit_price_s;
          state_s    = hit_price_s ? ST_VEND : ST_CREDIT;
        end else begin
          coin_reject_s = bus.I;
        end
      end
      ST_CREDIT: begin
        // Cancel outranks a coin arriving in the same cycle
        if (bus.cancel) begin
          state_s       = ST_REFUND;
          chg_req_s     = 1'b1;
          coin_reject_s = bus.I;
        end else if (accept_s) begin
          credit_s   = sum_s[3:0];
          vend_req_s = hit_price_s;
          state_s    = hit_price_s ? ST_VEND : ST_CREDIT;
        end else begin
          coin_reject_s = bus.I;
`ifdef VEND_TIMEOUT_EN
          if (tmo_r == TMO_L) begin
            state_s   = ST_REFUND;
            chg_req_s = 1'b1;
          end else begin
            tmo_s = tmo_r + TMO_W'(1);
          end
`endif
        end
      end
      ST_VEND: begin
        coin_reject_s = bus.I;
        if (bus.vend_ack && vend_req_r) begin
          credit_s = credit_r - PRICE4_L;
          if (credit_r != PRICE4_L) begin
            state_s   = ST_CHANGE;
            chg_req_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          vend_req_s = 1'b1;
        end
      end
      ST_CHANGE, ST_REFUND: begin
        coin_reject_s = bus.I;
        // Each acknowledged coin drops the request for one cycle
        if (bus.chg_ack && chg_req_r) begin
          credit_s = credit_r - 4'd1;
          if (credit_r == 4'd1) begin
            state_s = ST_IDLE;
          end else begin
            state_s = state_r;
          end
        end else if (credit_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          chg_req_s = 1'b1;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        credit_s = 4'd0;
      end
    endcase
    busy_s = (state_s == ST_VEND) || (state_s == ST_CHANGE) || (state_s == ST_REFUND);
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      credit_r      <= 4'd0;
      vend_req_r    <= 1'b0;
      chg_req_r     <= 1'b0;
      coin_reject_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      credit_r      <= credit_s;
      vend_req_r    <= vend_req_s;
      chg_req_r     <= chg_req_s;
      coin_reject_r <= coin_reject_s;
      busy_r        <= busy_s;
    end
  end

`ifdef VEND_TIMEOUT_EN
  // Inactivity counter for the CREDIT auto-refund
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_r <= '0;
    end else begin
      tmo_r <= tmo_s;
    end
  end
`endif

  assign bus.vend_req    = vend_req_r;
  assign bus.chg_req     = chg_req_r;
  assign bus.coin_reject = coin_reject_r;
  assign bus.credit      = credit_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_vend_scheduler.sv
// Self-checking bench for vend_scheduler: directed vector table, corner sequences,
// and randomized traffic against a credit/obligation reference model.
module tb_vend_scheduler;

  localparam int P = 3;
  localparam int M = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  vend_if if0 ();
  vend_if if7 ();

  vend_scheduler #(.PRICE_UNITS(P), .MAX_UNITS(M), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  vend_scheduler #(.PRICE_UNITS(7), .MAX_UNITS(7), .TIMEOUT_CYC(20)) dut7 (
    .clk(clk), .reset(reset), .bus(if7.slave)
  );

  always #5 clk = ~clk;

  // inputs {I,J,cancel,vend_ack,chg_ack}; outputs {vend_req,chg_req,coin_reject,busy,credit[3:0]}
  typedef struct packed {
    logic [4:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[26];

  function automatic logic [7:0] pk0();
    return {if0.vend_req, if0.chg_req, if0.coin_reject, if0.busy, if0.credit};
  endfunction

  function automatic logic [7:0] pk7();
    return {if7.vend_req, if7.chg_req, if7.coin_reject, if7.busy, if7.credit};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [4:0] v);
    {if0.I, if0.J, if0.cancel, if0.vend_ack, if0.chg_ack} = v;
  endtask

  task automatic drv7(input logic [4:0] v);
    {if7.I, if7.J, if7.cancel, if7.vend_ack, if7.chg_ack} = v;
  endtask

  // Reference model: credit held plus outstanding vend / payout obligations
  int  m_credit;
  bit  m_vend, m_pay, m_gap, m_rej;

  function automatic logic [7:0] m_exp();
    return {m_vend, m_pay && !m_gap, m_rej, m_vend || m_pay, 4'(m_credit)};
  endfunction

  task automatic m_update(input bit i, input bit j, input bit cn, input bit va, input bit ca);
    int v;
    m_rej = 1'b0;
    if (m_vend) begin
      m_rej = i;
      if (va) begin
        m_credit -= P;
        m_vend = 1'b0;
        m_pay = (m_credit > 0);
        m_gap = 1'b0;
      end
    end else if (m_pay) begin
      m_rej = i;
      if (m_gap) m_gap = 1'b0;
      else if (ca) begin
        m_credit -= 1;
        m_gap = 1'b1;
        if (m_credit == 0) begin
          m_pay = 1'b0;
          m_gap = 1'b0;
        end
      end
    end else if (m_credit > 0 && cn) begin
      m_pay = 1'b1;
      m_gap = 1'b0;
      m_rej = i;
    end else if (i) begin
      v = j ? 2 : 1;
      if (m_credit + v > M) m_rej = 1'b1;
      else begin
        m_credit += v;
        m_vend = (m_credit >= P);
      end
    end
  endtask

  initial begin
    int cnt;
    bit ok;
    bit ri, rj, rc, rva, rca;

    vecs[0]  = {5'b10000, 8'h01};
    vecs[1]  = {5'b11000, 8'h93};
    vecs[2]  = {5'b00000, 8'h93};
    vecs[3]  = {5'b00010, 8'h00};
    vecs[4]  = {5'b11000, 8'h02};
    vecs[5]  = {5'b11000, 8'h94};
    vecs[6]  = {5'b00000, 8'h94};
    vecs[7]  = {5'b00010, 8'h51};
    vecs[8]  = {5'b00000, 8'h51};
    vecs[9]  = {5'b00001, 8'h00};
    vecs[10] = {5'b10000, 8'h01};
    vecs[11] = {5'b10000, 8'h02};
    vecs[12] = {5'b10000, 8'h93};
    vecs[13] = {5'b11000, 8'hB3};
    vecs[14] = {5'b00010, 8'h00};
    vecs[15] = {5'b11000, 8'h02};
    vecs[16] = {5'b00100, 8'h52};
    vecs[17] = {5'b00100, 8'h52};
    vecs[18] = {5'b00001, 8'h11};
    vecs[19] = {5'b00001, 8'h51};
    vecs[20] = {5'b00001, 8'h00};
    vecs[21] = {5'b00100, 8'h00};
    vecs[22] = {5'b00010, 8'h00};
    vecs[23] = {5'b10000, 8'h01};
    vecs[24] = {5'b11100, 8'h71};
    vecs[25] = {5'b00001, 8'h00};

    drv0(5'b00000);
    drv7(5'b00000);
    repeat (3) step();
    chk("reset_dut", pk0(), 8'h00);
    chk("reset_dut7", pk7(), 8'h00);
    reset = 1'b1;
    step();

    for (int k = 0; k < 26; k++) begin
      drv0(vecs[k].in);
      step();
      chk($sformatf("vec%0d", k), pk0(), vecs[k].exp);
    end
    drv0(5'b00000);

    // Full credit at price 7: overflow reject, vend, coin during vend
    drv7(5'b11000); step(); chk("p7_c2", pk7(), 8'h02);
    step(); chk("p7_c4", pk7(), 8'h04);
    step(); chk("p7_c6", pk7(), 8'h06);
    step(); chk("p7_overflow", pk7(), 8'h26);
    drv7(5'b00000); step(); chk("p7_rej_pulse", pk7(), 8'h06);
    drv7(5'b10000); step(); chk("p7_vend", pk7(), 8'h97);
    step(); chk("p7_vend_coin", pk7(), 8'hB7);
    drv7(5'b00010); step(); chk("p7_done", pk7(), 8'h00);
    drv7(5'b00000);

    // Reset in the middle of a change payout
    drv0(5'b11000); step(); step();
    chk("mid_vend", pk0(), 8'h94);
    drv0(5'b00010); step();
    chk("mid_change", pk0(), 8'h51);
    drv0(5'b00000);
    #2 reset = 1'b0;
    #1 chk("async_reset", pk0(), 8'h00);
    step();
    reset = 1'b1;
    step(); step();
    chk("no_change_kept", pk0(), 8'h00);

`ifdef VEND_TIMEOUT_EN
    drv0(5'b10000); step(); drv0(5'b00000);
    cnt = 0;
    while (!if0.chg_req && cnt < 40) begin
      step();
      cnt++;
    end
    chk("timeout_refund", {7'd0, (cnt >= 19 && cnt <= 23)}, 8'h01);
    chk("timeout_state", pk0(), 8'h51);
    drv0(5'b00001); step(); drv0(5'b00000);
    chk("timeout_paid", pk0(), 8'h00);
`else
    drv0(5'b10000); step(); drv0(5'b00000);
    ok = 1'b1;
    repeat (100) begin
      step();
      if (pk0() !== 8'h01) ok = 1'b0;
    end
    chk("credit_held", {7'd0, ok}, 8'h01);
    drv0(5'b00100); step(); drv0(5'b00000);
    chk("hold_cancel", pk0(), 8'h51);
    drv0(5'b00001); step(); drv0(5'b00000);
    chk("hold_refunded", pk0(), 8'h00);

    // Randomized traffic vs reference model
    m_credit = 0; m_vend = 1'b0; m_pay = 1'b0; m_gap = 1'b0; m_rej = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ri  = ($urandom_range(0, 2) == 0);
      rj  = 1'($urandom_range(0, 1));
      rc  = ($urandom_range(0, 7) == 0);
      rva = 1'($urandom_range(0, 1));
      rca = 1'($urandom_range(0, 1));
      drv0({ri, rj, rc, rva, rca});
      step();
      m_update(ri, rj, rc, rva, rca);
      chk($sformatf("rand%0d", c), pk0(), m_exp());
      if (if0.vend_req && if0.chg_req) chk("req_exclusive", 8'h01, 8'h00);
    end
    drv0(5'b00000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
